// File: rtl/axi4_lite_pkg.sv
// Shared response codes and FSM state encodings for the AXI4-Lite master.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE      = 2'd0,
    W_ADDR_DATA = 2'd1,
    W_RESP      = 2'd2
  } wr_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axi4_lite_timeout_counter.sv
// Per-transaction watchdog: counts busy cycles and flags when the budget is used up.
module axi4_lite_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic aclk,
  input  logic areset,
  input  logic run_in,
  output logic expired_out
);

  if (TIMEOUT_CYCLES == 0) begin : g_off
    assign expired_out = 1'b0;
  end else begin : g_on
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Clear while idle, count busy cycles, saturate at the budget.
    always_comb begin
      count_d = '0;
      if (run_in) begin
        if (32'(count_q) < TIMEOUT_CYCLES) begin
          count_d = count_q + CNT_W'(1);
        end else begin
          count_d = count_q;
        end
      end
    end

    // Counter register.
    always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
        count_q <= '0;
      end else begin
        count_q <= count_d;
      end
    end

    // Elapsed time includes the accepting cycle and the current one, so the
    // abort pulse lands exactly TIMEOUT_CYCLES cycles after the request edge.
    assign expired_out = run_in && ((32'(count_q) + 32'd2) >= TIMEOUT_CYCLES);
  end

endmodule

// File: rtl/axi4_lite_master_ctrl.sv
// AXI4-Lite master: independent write and read engines with timeout abort.
module axi4_lite_master_ctrl
  import axi4_lite_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  wr_req_in,
  input  logic [ADDR_WIDTH-1:0] wr_addr_in,
  input  logic [DATA_WIDTH-1:0] wr_data_in,
  input  logic [STRB_WIDTH-1:0] wr_strb_in,
  input  logic [2:0]            wr_prot_in,
  output logic                  wr_ready_out,
  output logic                  wr_done_out,
  output logic [1:0]            wr_resp_out,
  output logic                  wr_timeout_out,
  input  logic                  rd_req_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [2:0]            rd_prot_in,
  output logic                  rd_ready_out,
  output logic                  rd_done_out,
  output logic [DATA_WIDTH-1:0] rd_data_out,
  output logic [1:0]            rd_resp_out,
  output logic                  rd_timeout_out,
  output logic [ADDR_WIDTH-1:0] awaddr_out,
  output logic [2:0]            awprot_out,
  output logic                  awvalid_out,
  input  logic                  awready_in,
  output logic [DATA_WIDTH-1:0] wdata_out,
  output logic [STRB_WIDTH-1:0] wstrb_out,
  output logic                  wvalid_out,
  input  logic                  wready_in,
  input  logic [1:0]            bresp_in,
  input  logic                  bvalid_in,
  output logic                  bready_out,
  output logic [ADDR_WIDTH-1:0] araddr_out,
  output logic [2:0]            arprot_out,
  output logic                  arvalid_out,
  input  logic                  arready_in,
  input  logic [DATA_WIDTH-1:0] rdata_in,
  input  logic [1:0]            rresp_in,
  input  logic                  rvalid_in,
  output logic                  rready_out
);

  // ---------------------------------------------------------------- write
  wr_state_e             w_state_q, w_state_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  aw_done_q, aw_done_d;
  logic                  w_done_q, w_done_d;
  logic                  wr_ready_q, wr_ready_d;
  logic                  wr_done_q, wr_done_d;
  logic                  wr_timeout_q, wr_timeout_d;
  logic [1:0]            wr_resp_q, wr_resp_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [2:0]            awprot_q, awprot_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  wr_expired;
  logic                  aw_hs, w_hs, aw_fin, w_fin;

  assign aw_hs  = awvalid_q && awready_in;
  assign w_hs   = wvalid_q && wready_in;
  assign aw_fin = aw_done_q || aw_hs;
  assign w_fin  = w_done_q || w_hs;

  axi4_lite_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wr_timeout (
    .aclk       (aclk),
    .areset     (areset),
    .run_in     (w_state_q != W_IDLE),
    .expired_out(wr_expired)
  );

  // Write state and output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q    <= W_IDLE;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      wr_ready_q   <= 1'b1;
      wr_done_q    <= 1'b0;
      wr_timeout_q <= 1'b0;
      wr_resp_q    <= RESP_OKAY;
      awaddr_q     <= '0;
      awprot_q     <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      w_state_q    <= w_state_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      aw_done_q    <= aw_done_d;
      w_done_q     <= w_done_d;
      wr_ready_q   <= wr_ready_d;
      wr_done_q    <= wr_done_d;
      wr_timeout_q <= wr_timeout_d;
      wr_resp_q    <= wr_resp_d;
      awaddr_q     <= awaddr_d;
      awprot_q     <= awprot_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // Write next state; a handshake in the expiry cycle beats the abort.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:      if (wr_req_in) w_state_d = W_ADDR_DATA;
      W_ADDR_DATA: begin
        if (aw_fin && w_fin)  w_state_d = W_RESP;
        else if (wr_expired)  w_state_d = W_IDLE;
      end
      W_RESP:      if (bvalid_in || wr_expired) w_state_d = W_IDLE;
      default:     w_state_d = W_IDLE;
    endcase
  end

  // Write outputs for the next cycle.
  always_comb begin
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    aw_done_d    = aw_done_q;
    w_done_d     = w_done_q;
    wr_ready_d   = wr_ready_q;
    wr_done_d    = 1'b0;
    wr_timeout_d = 1'b0;
    wr_resp_d    = wr_resp_q;
    awaddr_d     = awaddr_q;
    awprot_d     = awprot_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    case (w_state_q)
      W_IDLE: begin
        wr_ready_d = 1'b1;
        if (wr_req_in) begin
          awaddr_d   = wr_addr_in;
          awprot_d   = wr_prot_in;
          wdata_d    = wr_data_in;
          wstrb_d    = wr_strb_in;
          awvalid_d  = 1'b1;
          wvalid_d   = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          wr_ready_d = 1'b0;
        end
      end
      W_ADDR_DATA: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_fin && w_fin) begin
          bready_d = 1'b1;
        end else if (wr_expired) begin
          awvalid_d    = 1'b0;
          wvalid_d     = 1'b0;
          wr_resp_d    = RESP_SLVERR;
          wr_done_d    = 1'b1;
          wr_timeout_d = 1'b1;
          wr_ready_d   = 1'b1;
        end
      end
      W_RESP: begin
        if (bvalid_in) begin
          bready_d   = 1'b0;
          wr_resp_d  = bresp_in;
          wr_done_d  = 1'b1;
          wr_ready_d = 1'b1;
        end else if (wr_expired) begin
          bready_d     = 1'b0;
          wr_resp_d    = RESP_SLVERR;
          wr_done_d    = 1'b1;
          wr_timeout_d = 1'b1;
          wr_ready_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ----------------------------------------------------------------- read
  rd_state_e             r_state_q, r_state_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rd_ready_q, rd_ready_d;
  logic                  rd_done_q, rd_done_d;
  logic                  rd_timeout_q, rd_timeout_d;
  logic [1:0]            rd_resp_q, rd_resp_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic [2:0]            arprot_q, arprot_d;
  logic                  rd_expired;
  logic                  ar_hs;

  assign ar_hs = arvalid_q && arready_in;

  axi4_lite_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rd_timeout (
    .aclk       (aclk),
    .areset     (areset),
    .run_in     (r_state_q != R_IDLE),
    .expired_out(rd_expired)
  );

  // Read state and output registers.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q    <= R_IDLE;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rd_ready_q   <= 1'b1;
      rd_done_q    <= 1'b0;
      rd_timeout_q <= 1'b0;
      rd_resp_q    <= RESP_OKAY;
      rd_data_q    <= '0;
      araddr_q     <= '0;
      arprot_q     <= '0;
    end else begin
      r_state_q    <= r_state_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      rd_ready_q   <= rd_ready_d;
      rd_done_q    <= rd_done_d;
      rd_timeout_q <= rd_timeout_d;
      rd_resp_q    <= rd_resp_d;
      rd_data_q    <= rd_data_d;
      araddr_q     <= araddr_d;
      arprot_q     <= arprot_d;
    end
  end

  // Read next state.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (rd_req_in) r_state_d = R_ADDR;
      R_ADDR: begin
        if (ar_hs)           r_state_d = R_DATA;
        else if (rd_expired) r_state_d = R_IDLE;
      end
      R_DATA:  if (rvalid_in || rd_expired) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read outputs for the next cycle; read data is left untouched on abort.
  always_comb begin
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    rd_ready_d   = rd_ready_q;
    rd_done_d    = 1'b0;
    rd_timeout_d = 1'b0;
    rd_resp_d    = rd_resp_q;
    rd_data_d    = rd_data_q;
    araddr_d     = araddr_q;
    arprot_d     = arprot_q;
    case (r_state_q)
      R_IDLE: begin
        rd_ready_d = 1'b1;
        if (rd_req_in) begin
          araddr_d   = rd_addr_in;
          arprot_d   = rd_prot_in;
          arvalid_d  = 1'b1;
          rd_ready_d = 1'b0;
        end
      end
      R_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
        end else if (rd_expired) begin
          arvalid_d    = 1'b0;
          rd_resp_d    = RESP_SLVERR;
          rd_done_d    = 1'b1;
          rd_timeout_d = 1'b1;
          rd_ready_d   = 1'b1;
        end
      end
      R_DATA: begin
        if (rvalid_in) begin
          rready_d   = 1'b0;
          rd_data_d  = rdata_in;
          rd_resp_d  = rresp_in;
          rd_done_d  = 1'b1;
          rd_ready_d = 1'b1;
        end else if (rd_expired) begin
          rready_d     = 1'b0;
          rd_resp_d    = RESP_SLVERR;
          rd_done_d    = 1'b1;
          rd_timeout_d = 1'b1;
          rd_ready_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- ports
  assign wr_ready_out   = wr_ready_q;
  assign wr_done_out    = wr_done_q;
  assign wr_resp_out    = wr_resp_q;
  assign wr_timeout_out = wr_timeout_q;
  assign awaddr_out     = awaddr_q;
  assign awprot_out     = awprot_q;
  assign awvalid_out    = awvalid_q;
  assign wdata_out      = wdata_q;
  assign wstrb_out      = wstrb_q;
  assign wvalid_out     = wvalid_q;
  assign bready_out     = bready_q;
  assign rd_ready_out   = rd_ready_q;
  assign rd_done_out    = rd_done_q;
  assign rd_data_out    = rd_data_q;
  assign rd_resp_out    = rd_resp_q;
  assign rd_timeout_out = rd_timeout_q;
  assign araddr_out     = araddr_q;
  assign arprot_out     = arprot_q;
  assign arvalid_out    = arvalid_q;
  assign rready_out     = rready_q;

endmodule

// File: tb/tb_axi4_lite_master_ctrl.sv
// Directed plus randomized bench for the AXI4-Lite master, with a timeline model.
module tb_axi4_lite_master_ctrl;
  import axi4_lite_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          aclk = 1'b0;
  logic          areset;
  logic          wr_req_in, wr_ready_out, wr_done_out, wr_timeout_out;
  logic [AW-1:0] wr_addr_in;
  logic [DW-1:0] wr_data_in;
  logic [SW-1:0] wr_strb_in;
  logic [2:0]    wr_prot_in;
  logic [1:0]    wr_resp_out;
  logic          rd_req_in, rd_ready_out, rd_done_out, rd_timeout_out;
  logic [AW-1:0] rd_addr_in;
  logic [2:0]    rd_prot_in;
  logic [DW-1:0] rd_data_out;
  logic [1:0]    rd_resp_out;
  logic [AW-1:0] awaddr_out, araddr_out;
  logic [2:0]    awprot_out, arprot_out;
  logic          awvalid_out, awready_in, wvalid_out, wready_in;
  logic [DW-1:0] wdata_out, rdata_in;
  logic [SW-1:0] wstrb_out;
  logic [1:0]    bresp_in, rresp_in;
  logic          bvalid_in, bready_out, arvalid_out, arready_in, rvalid_in, rready_out;

  always #5 aclk = ~aclk;

  axi4_lite_master_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STRB_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk), .areset(areset),
    .wr_req_in(wr_req_in), .wr_addr_in(wr_addr_in), .wr_data_in(wr_data_in),
    .wr_strb_in(wr_strb_in), .wr_prot_in(wr_prot_in), .wr_ready_out(wr_ready_out),
    .wr_done_out(wr_done_out), .wr_resp_out(wr_resp_out), .wr_timeout_out(wr_timeout_out),
    .rd_req_in(rd_req_in), .rd_addr_in(rd_addr_in), .rd_prot_in(rd_prot_in),
    .rd_ready_out(rd_ready_out), .rd_done_out(rd_done_out), .rd_data_out(rd_data_out),
    .rd_resp_out(rd_resp_out), .rd_timeout_out(rd_timeout_out),
    .awaddr_out(awaddr_out), .awprot_out(awprot_out), .awvalid_out(awvalid_out),
    .awready_in(awready_in), .wdata_out(wdata_out), .wstrb_out(wstrb_out),
    .wvalid_out(wvalid_out), .wready_in(wready_in), .bresp_in(bresp_in),
    .bvalid_in(bvalid_in), .bready_out(bready_out), .araddr_out(araddr_out),
    .arprot_out(arprot_out), .arvalid_out(arvalid_out), .arready_in(arready_in),
    .rdata_in(rdata_in), .rresp_in(rresp_in), .rvalid_in(rvalid_in), .rready_out(rready_out)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference state: last reported responses / data per direction.
  logic [1:0]    last_wr_resp = RESP_OKAY;
  logic [1:0]    last_rd_resp = RESP_OKAY;
  logic [DW-1:0] last_rd_data = '0;
  bit            rd_data_known = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic slave_idle();
    awready_in = 1'b0; wready_in = 1'b0; bvalid_in = 1'b0; bresp_in = RESP_OKAY;
    arready_in = 1'b0; rvalid_in = 1'b0; rdata_in = '0; rresp_in = RESP_OKAY;
  endtask

  // Start at posedge+1 with both engines idle. Delays are cycles between a
  // valid/ready rising and the slave answering; the model derives the whole
  // timeline (handshake cycles, done cycle, abort) from them.
  task automatic run_txn(
    input bit do_wr, input logic [AW-1:0] waddr, input logic [DW-1:0] wdata,
    input logic [SW-1:0] wstrb, input logic [2:0] wprot,
    input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] bresp,
    input bit do_rd, input logic [AW-1:0] raddr, input logic [2:0] rprot,
    input int ar_dly, input int r_dly, input logic [DW-1:0] rdata, input logic [1:0] rresp);
    int aw_hs, w_hs, b_start, b_hs, wdone, ar_hs, r_start, r_hs, rdone, last;
    bit wto, rto;
    logic [1:0] new_wr_resp, new_rd_resp;
    wto = 1'b0; rto = 1'b0;
    aw_hs = 0; w_hs = 0; b_start = 0; b_hs = 0; wdone = 0;
    ar_hs = 0; r_start = 0; r_hs = 0; rdone = 0;
    new_wr_resp = last_wr_resp;
    new_rd_resp = last_rd_resp;
    if (do_wr) begin
      aw_hs   = 1 + aw_dly;
      w_hs    = 1 + w_dly;
      b_start = ((aw_hs > w_hs) ? aw_hs : w_hs) + 1;
      b_hs    = b_start + b_dly;
      wto     = (b_hs > TO - 1);
      wdone   = wto ? TO : b_hs + 1;
      new_wr_resp = wto ? RESP_SLVERR : bresp;
    end
    if (do_rd) begin
      ar_hs   = 1 + ar_dly;
      r_start = ar_hs + 1;
      r_hs    = r_start + r_dly;
      rto     = (r_hs > TO - 1);
      rdone   = rto ? TO : r_hs + 1;
      new_rd_resp = rto ? RESP_SLVERR : rresp;
    end
    last = ((wdone > rdone) ? wdone : rdone) + 1;

    cyc = 0;
    wr_req_in = do_wr; wr_addr_in = waddr; wr_data_in = wdata;
    wr_strb_in = wstrb; wr_prot_in = wprot;
    rd_req_in = do_rd; rd_addr_in = raddr; rd_prot_in = rprot;
    for (int c = 1; c <= last; c++) begin
      @(posedge aclk); #1;
      cyc = c;
      wr_req_in  = 1'b0;
      rd_req_in  = 1'b0;
      awready_in = do_wr && (c >= aw_hs);
      wready_in  = do_wr && (c >= w_hs);
      bvalid_in  = do_wr && (c >= b_hs) && (c < wdone);
      bresp_in   = bresp;
      arready_in = do_rd && (c >= ar_hs);
      rvalid_in  = do_rd && (c >= r_hs) && (c < rdone);
      rdata_in   = rdata;
      rresp_in   = rresp;

      chk("awvalid", awvalid_out, do_wr && c <= aw_hs && c < wdone);
      chk("wvalid", wvalid_out, do_wr && c <= w_hs && c < wdone);
      chk("bready", bready_out, do_wr && c >= b_start && c < wdone);
      chk("wr_ready", wr_ready_out, !do_wr || c >= wdone);
      chk("wr_done", wr_done_out, do_wr && c == wdone);
      chk("wr_timeout", wr_timeout_out, do_wr && wto && c == wdone);
      chk("wr_resp", wr_resp_out, (do_wr && c >= wdone) ? new_wr_resp : last_wr_resp);
      if (do_wr && c <= aw_hs && c < wdone) begin
        chk("awaddr", awaddr_out, waddr);
        chk("awprot", awprot_out, wprot);
      end
      if (do_wr && c <= w_hs && c < wdone) begin
        chk("wdata", wdata_out, wdata);
        chk("wstrb", wstrb_out, wstrb);
      end

      chk("arvalid", arvalid_out, do_rd && c <= ar_hs && c < rdone);
      chk("rready", rready_out, do_rd && c >= r_start && c < rdone);
      chk("rd_ready", rd_ready_out, !do_rd || c >= rdone);
      chk("rd_done", rd_done_out, do_rd && c == rdone);
      chk("rd_timeout", rd_timeout_out, do_rd && rto && c == rdone);
      chk("rd_resp", rd_resp_out, (do_rd && c >= rdone) ? new_rd_resp : last_rd_resp);
      if (do_rd && c <= ar_hs && c < rdone) begin
        chk("araddr", araddr_out, raddr);
        chk("arprot", arprot_out, rprot);
      end
      if (rd_data_known && !(do_rd && rto && c >= rdone))
        chk("rd_data", rd_data_out, (do_rd && c >= rdone) ? rdata : last_rd_data);
    end
    slave_idle();
    if (do_wr) last_wr_resp = new_wr_resp;
    if (do_rd) begin
      last_rd_resp = new_rd_resp;
      if (rto) rd_data_known = 1'b0;
      else begin
        last_rd_data  = rdata;
        rd_data_known = 1'b1;
      end
    end
  endtask

  logic [AW-1:0] ra, wa;
  logic [DW-1:0] rd, wd;
  bit            dw, dr;

  initial begin
    areset = 1'b1;
    wr_req_in = 1'b0; wr_addr_in = '0; wr_data_in = '0; wr_strb_in = '0; wr_prot_in = '0;
    rd_req_in = 1'b0; rd_addr_in = '0; rd_prot_in = '0;
    slave_idle();

    // Reset state held for two cycles.
    repeat (2) begin
      @(posedge aclk); #1;
      chk("rst_awvalid", awvalid_out, 1'b0);
      chk("rst_wvalid", wvalid_out, 1'b0);
      chk("rst_bready", bready_out, 1'b0);
      chk("rst_arvalid", arvalid_out, 1'b0);
      chk("rst_rready", rready_out, 1'b0);
      chk("rst_wr_ready", wr_ready_out, 1'b1);
      chk("rst_rd_ready", rd_ready_out, 1'b1);
      chk("rst_wr_done", wr_done_out, 1'b0);
      chk("rst_rd_done", rd_done_out, 1'b0);
      chk("rst_wr_resp", wr_resp_out, 2'b00);
      chk("rst_rd_resp", rd_resp_out, 2'b00);
      chk("rst_rd_data", rd_data_out, '0);
    end
    areset = 1'b0;
    @(posedge aclk); #1;

    // Minimum-latency write.
    run_txn(1, 32'h10, 32'hF0B4A596, 4'b1011, 3'd4, 0, 0, 0, RESP_OKAY,
            0, '0, '0, 0, 0, '0, RESP_OKAY);
    // Staggered write: awready c2, wready c6, bvalid c9, SLVERR.
    run_txn(1, 32'h24, 32'h12345678, 4'b0110, 3'd1, 1, 5, 2, RESP_SLVERR,
            0, '0, '0, 0, 0, '0, RESP_OKAY);
    // Read with rvalid late.
    run_txn(0, '0, '0, '0, '0, 0, 0, 0, RESP_OKAY,
            1, 32'h80, 3'd2, 0, 3, 32'hF0B4A596, RESP_OKAY);
    // Write timeout: awready never comes.
    run_txn(1, 32'h30, 32'hDEADBEEF, 4'hF, 3'd0, 1000, 0, 0, RESP_OKAY,
            0, '0, '0, 0, 0, '0, RESP_OKAY);
    // B handshake on the expiry cycle completes normally; one later aborts.
    run_txn(1, 32'h34, 32'hA5A5A5A5, 4'hF, 3'd0, 0, 0, 13, RESP_EXOKAY,
            0, '0, '0, 0, 0, '0, RESP_OKAY);
    run_txn(1, 32'h38, 32'h5A5A5A5A, 4'hF, 3'd0, 0, 0, 14, RESP_OKAY,
            0, '0, '0, 0, 0, '0, RESP_OKAY);
    // Read timeouts and the R-channel boundary.
    run_txn(0, '0, '0, '0, '0, 0, 0, 0, RESP_OKAY,
            1, 32'h90, 3'd0, 1000, 0, 32'h11111111, RESP_OKAY);
    run_txn(0, '0, '0, '0, '0, 0, 0, 0, RESP_OKAY,
            1, 32'h94, 3'd7, 0, 13, 32'h22222222, RESP_DECERR);
    run_txn(0, '0, '0, '0, '0, 0, 0, 0, RESP_OKAY,
            1, 32'h98, 3'd0, 0, 14, 32'h33333333, RESP_OKAY);
    // Concurrent write and read.
    run_txn(1, 32'h40, 32'hCAFEF00D, 4'b0001, 3'd3, 2, 0, 1, RESP_OKAY,
            1, 32'hA0, 3'd5, 1, 2, 32'h0BADC0DE, RESP_EXOKAY);

    // Randomized transactions, occasionally long enough to time out.
    for (int i = 0; i < 30; i++) begin
      dw = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      if (!dw && !dr) dw = 1'b1;
      wa = $urandom; wd = $urandom; ra = $urandom; rd = $urandom;
      run_txn(dw, wa, wd, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
              int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 16)), 2'($urandom_range(0, 3)),
              dr, ra, 3'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
              int'($urandom_range(0, 16)), rd, 2'($urandom_range(0, 3)));
    end

    // Both directions start; reset lands while the read waits for arready.
    cyc = 0;
    wr_req_in = 1'b1; wr_addr_in = 32'h50; wr_data_in = 32'h77; wr_strb_in = 4'hF; wr_prot_in = 3'd0;
    rd_req_in = 1'b1; rd_addr_in = 32'hB0; rd_prot_in = 3'd0;
    awready_in = 1'b1; wready_in = 1'b1; bvalid_in = 1'b1; bresp_in = RESP_OKAY;
    @(posedge aclk); #1; cyc = 1;
    wr_req_in = 1'b0; rd_req_in = 1'b0;
    chk("mr_awvalid", awvalid_out, 1'b1);
    chk("mr_arvalid", arvalid_out, 1'b1);
    @(posedge aclk); #1; cyc = 2;
    chk("mr_bready", bready_out, 1'b1);
    chk("mr_arvalid2", arvalid_out, 1'b1);
    @(posedge aclk); #1; cyc = 3;
    chk("mr_wr_done", wr_done_out, 1'b1);
    chk("mr_wr_resp", wr_resp_out, RESP_OKAY);
    chk("mr_rd_busy", rd_ready_out, 1'b0);
    slave_idle();
    #2 areset = 1'b1;
    #1;
    chk("mr_async_arvalid", arvalid_out, 1'b0);
    chk("mr_async_rready", rready_out, 1'b0);
    chk("mr_async_rd_ready", rd_ready_out, 1'b1);
    chk("mr_async_rd_done", rd_done_out, 1'b0);
    repeat (2) begin
      @(posedge aclk); #1; cyc++;
      chk("mr_hold_rd_done", rd_done_out, 1'b0);
      chk("mr_hold_arvalid", arvalid_out, 1'b0);
    end
    areset = 1'b0;
    last_wr_resp = RESP_OKAY; last_rd_resp = RESP_OKAY;
    last_rd_data = '0; rd_data_known = 1'b1;
    @(posedge aclk); #1; cyc++;
    chk("mr_post_rd_done", rd_done_out, 1'b0);
    chk("mr_post_rd_ready", rd_ready_out, 1'b1);

    // Recovery after reset.
    run_txn(1, 32'h60, 32'h13579BDF, 4'hC, 3'd6, 0, 1, 0, RESP_DECERR,
            1, 32'hC0, 3'd1, 0, 0, 32'h2468ACE0, RESP_OKAY);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi4_lite_master_ctrl.md
Name: axi4_lite_master_ctrl

Overview:
- Parametrised AXI4-Lite master with a simple user-side request/done interface, one per direction.
- Write and read paths are independent.
- AW and W are issued concurrently, and each deasserts on its own handshake.
- Adds a per-transaction timeout abort and registered response capture.
- Sits between bus-owning logic (DMA/CPU shim) and the AXI4-Lite interconnect.

Parameters:
- ADDR_WIDTH, 32, address width of awaddr/araddr.
- DATA_WIDTH, 32, data width; must be 32 or 64.
- STRB_WIDTH, DATA_WIDTH/8, derived; do not override.
- TIMEOUT_CYCLES, 256, max cycles a transaction may stay non-idle; 0 disables the timeout.

Ports:
- aclk  in  1  clock, all logic rising-edge.
- areset  in  1  asynchronous, active-high reset.
- wr_req_in  in  1  user write request; accepted when wr_ready_out=1.
- wr_addr_in  in  ADDR_WIDTH  write address.
- wr_data_in  in  DATA_WIDTH  write data.
- wr_strb_in  in  STRB_WIDTH  byte strobes.
- wr_prot_in  in  3  protection bits.
- wr_ready_out  out  1  write FSM idle.
- wr_done_out  out  1  one-cycle pulse, write finished.
- wr_resp_out  out  2  BRESP, or SLVERR on timeout; held until the next done.
- wr_timeout_out  out  1  one-cycle pulse with wr_done_out when the write aborted.
- rd_req_in  in  1  user read request.
- rd_addr_in  in  ADDR_WIDTH  read address.
- rd_prot_in  in  3  protection bits.
- rd_ready_out  out  1  read FSM idle.
- rd_done_out  out  1  one-cycle pulse, read finished.
- rd_data_out  out  DATA_WIDTH  captured RDATA, held.
- rd_resp_out  out  2  RRESP, or SLVERR on timeout, held.
- rd_timeout_out  out  1  timeout pulse.
- awaddr_out/awprot_out/awvalid_out  out  ADDR_WIDTH/3/1;  awready_in  in  1.
- wdata_out/wstrb_out/wvalid_out  out  DATA_WIDTH/STRB_WIDTH/1;  wready_in  in  1.
- bresp_in  in  2;  bvalid_in  in  1;  bready_out  out  1.
- araddr_out/arprot_out/arvalid_out  out  ADDR_WIDTH/3/1;  arready_in  in  1.
- rdata_in  in  DATA_WIDTH;  rresp_in  in  2;  rvalid_in  in  1;  rready_out  out  1.

Behaviour:
- Reset state:
  - All outputs are registered.
  - While areset=1, all valid/ready-to-bus outputs, done, timeout, resp and data outputs are 0.
  - wr_ready_out=rd_ready_out=1; both FSMs are IDLE.
- Write FSM (W_IDLE, W_ADDR_DATA, W_RESP):
  - W_IDLE & wr_req_in: capture addr/data/strb/prot and go to W_ADDR_DATA. Next cycle awvalid_out=wvalid_out=1 and wr_ready_out=0.
  - W_ADDR_DATA: awvalid drops the cycle after awvalid&awready; wvalid drops the cycle after wvalid&wready; either order or simultaneous.
  - The payload stays stable while its valid is high.
  - When both handshakes are done (tracked by aw_done/w_done flags), go to W_RESP with bready_out=1.
  - W_RESP & bvalid_in: latch bresp_in, then the next cycle wr_done_out=1, bready_out=0, back to W_IDLE with wr_ready_out=1.
  - Minimum latency with all readies/bvalid held high: request sampled at edge 0, AW/W valid cycle 1, bready cycle 2, done cycle 3.
- Read FSM (R_IDLE, R_ADDR, R_DATA):
  - Same pattern: arvalid_out until the AR handshake, then rready_out=1 until rvalid_in.
  - Latch rdata/rresp, then rd_done_out pulses the next cycle.
  - Minimum latency 3 cycles.
- Concurrency:
  - Write and read FSMs run fully concurrently; no ordering is enforced between them.
  - A request while not ready is ignored; it is not queued.
- Timeout (per FSM):
  - The counter clears in IDLE and increments every non-idle cycle.
  - On reaching TIMEOUT_CYCLES: drop all bus valid/ready of that FSM, set resp=2'b10, and pulse done and timeout together.
  - Return to IDLE.
  - A handshake in the same cycle as expiry wins; it is a normal completion.
  - With TIMEOUT_CYCLES=0 the counter is never compared.
- Resp/data outputs hold their value until the next completion of the same direction.
- areset asserted mid-transaction aborts immediately to the reset state; no done pulse is produced.

Decomposition:
- Package axi4_lite_pkg:
  - Response codes RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - Write and read state encodings.
- Sub-module axi4_lite_timeout_counter:
  - Parameter TIMEOUT_CYCLES; ports aclk, areset, run_in, expired_out.
  - Instantiated once per FSM.

Test Plan:
- Reset then idle: areset=1 for 2 cycles → all valids 0, wr_ready_out=rd_ready_out=1, resp=0.
- Write, all readies high, bresp=0: addr=0x10, data=0xF0B4A596, strb=4'b1011, prot=4 → AW/W valid cycle 1, wr_done cycle 3, wr_resp=0.
- Staggered write: awready high at cycle 2, wready at cycle 6, bvalid at cycle 9 with bresp=2'b10:
  - awvalid low from cycle 3; wvalid low from cycle 7.
  - bready high from cycle 7; done cycle 10, resp=2'b10.
- Read, arready high, rvalid 4 cycles later with rdata=0xF0B4A596, rresp=0 → rd_data_out=0xF0B4A596, rd_done one pulse.
- Timeout: TIMEOUT_CYCLES=16, awready never high → at cycle 16, wr_done=wr_timeout=1, resp=2'b10, awvalid=wvalid=0, wr_ready_out=1 next cycle.
- Simultaneous write and read requests, then areset mid-read:
  - Both progress independently.
  - Reset drives arvalid/rready to 0 asynchronously with no rd_done pulse.
